// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, defaults and
// the address legality rule used on every request.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam int unsigned DM_DEPTH_WORDS_DEF = 1024;
    localparam int unsigned DM_WAIT_CYCLES_DEF = 2;
    localparam int unsigned DM_BE_W            = 4;

    // Word-aligned and inside the backing array.
    function automatic logic dm_addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dm_array.sv
// Synchronous word RAM with byte-enabled write and registered read; no reset,
// so contents survive a responder reset.
module dm_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS_DEF,
    parameter int unsigned AW          = 10
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [DM_BE_W-1:0] be,
    input  logic [AW-1:0]      idx,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    logic [31:0] mem [0:DEPTH_WORDS-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < DM_BE_W; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one request at a time, inserts WAIT_CYCLES
// wait states, then presents the response until the initiator consumes it.
module dm_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS_DEF,
    parameter int unsigned WAIT_CYCLES = DM_WAIT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [DM_BE_W-1:0] req_be,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic               busy
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dm_state_e          state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [DM_BE_W-1:0] be_q, be_d;
    logic               resp_valid_q, resp_valid_d;
    logic               err_q, err_d;
    logic               enter_resp;

    logic               acc_we;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [DM_BE_W-1:0] acc_be;
    logic               acc_err;
    logic [31:0]        arr_rdata;

    // RESP is entered straight from IDLE only when WAIT_CYCLES is 0; the array
    // must then see the live request because the captured copy is not yet valid.
    assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign acc_err   = dm_addr_err(acc_addr, DEPTH_WORDS);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_valid_d = resp_valid_q;
        err_d        = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_LOAD;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    err_d        = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
        if (enter_resp) begin
            resp_valid_d = 1'b1;
            err_d        = acc_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
        end
    end

    dm_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .en   (enter_resp),
        .we   (acc_we && !acc_err),
        .be   (acc_be),
        .idx  (acc_addr[AW+1:2]),
        .wdata(acc_wdata),
        .rdata(arr_rdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = (resp_valid_q && !err_q && !we_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: a WAIT_CYCLES=2 instance driven by
// directed and random transactions, plus a WAIT_CYCLES=0 instance streamed back-to-back.
module tb_dm_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W     = 2;
    localparam int unsigned NW    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        r0_valid, r0_we;
    logic [31:0] r0_addr, r0_wdata;
    logic [3:0]  r0_be;
    logic        r0_ready, r0_rvalid, r0_err, r0_busy;
    logic [31:0] r0_rdata;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] model [0:NW-1];

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst), .req_valid(r0_valid), .req_ready(r0_ready),
        .req_we(r0_we), .req_addr(r0_addr), .req_wdata(r0_wdata), .req_be(r0_be),
        .resp_valid(r0_rvalid), .resp_ready(1'b1), .resp_rdata(r0_rdata),
        .resp_err(r0_err), .busy(r0_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One complete transaction on the WAIT_CYCLES=2 instance, starting from idle.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int unsigned hold, input logic pulse);
        logic        exp_err;
        logic [31:0] exp_rd;
        int unsigned k;
        exp_err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
        exp_rd  = '0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                exp_rd = model[addr[7:2]];
            end
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        chk1("req_ready_idle", req_ready, 1'b1);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            k++;
        end while (!resp_valid && k < 20);
        chk("latency", k, W + 1);
        chk1("resp_err", resp_err, exp_err);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk1("busy_resp", busy, 1'b1);
        chk1("req_ready_resp", req_ready, 1'b0);
        for (int unsigned h = 0; h < hold; h++) begin
            if (pulse) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0004;
            end
            @(negedge clk);
            req_valid = 1'b0;
            chk1("hold_valid", resp_valid, 1'b1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk1("hold_err", resp_err, exp_err);
            chk1("hold_busy", busy, 1'b1);
            chk1("hold_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk1("valid_after_hs", resp_valid, 1'b0);
        chk1("ready_after_hs", req_ready, 1'b1);
        chk1("busy_after_hs", busy, 1'b0);
    endtask

    initial begin
        logic [31:0] s_addr [0:7];
        logic [31:0] s_wdata [0:7];
        logic        s_we [0:7];
        logic [31:0] s_exp [0:7];
        logic [31:0] m0 [0:3];
        logic [31:0] a, d;
        int unsigned sel, idx;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; resp_ready = 1'b0;
        r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_be = '0;
        repeat (2) @(negedge clk);
        chk1("rst_valid", resp_valid, 1'b0);
        chk1("rst_err", resp_err, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst0_ready", r0_ready, 1'b1);
        rst = 1'b0;

        for (int unsigned i = 0; i < NW; i++) txn(1'b1, i * 4, $urandom, 4'hF, 0, 1'b0);

        txn(1'b1, 32'h10, 32'h1234ABCD, 4'hF, 0, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
        chk("store_load_word", model[4], 32'h1234ABCD);

        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, 1'b0);
        txn(1'b1, 32'h20, 32'h0000EE00, 4'b0010, 0, 1'b0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
        chk("partial_store_model", model[8], 32'h1122EE44);

        txn(1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0);
        txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0);
        txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);
        txn(1'b1, 32'h24, 32'h5555_AAAA, 4'h0, 0, 1'b0);
        txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0);

        txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);

        // Reset one cycle after a store is accepted: the store must be dropped.
        txn(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
        chk1("rst_test_ready", req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk1("midrst_valid", resp_valid, 1'b0);
        chk1("midrst_ready", req_ready, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk1("postrst_valid", resp_valid, 1'b0);
        chk1("postrst_busy", busy, 1'b0);
        txn(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0);

        for (int unsigned t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            a = 32'($urandom_range(0, NW - 1)) * 4;
            if (sel == 0)      a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = a + 32'h1000;
            else if (sel == 2) a = $urandom | 32'h8000_0000;
            d = $urandom;
            txn(1'(($urandom % 2)), a, d, 4'($urandom), $urandom_range(0, 2), 1'($urandom % 2));
        end

        // Back-to-back stream on the zero-wait instance: responses alternate cycle by cycle.
        for (int unsigned i = 0; i < 4; i++) begin
            m0[i] = $urandom;
            s_we[i] = 1'b1; s_addr[i] = i * 4; s_wdata[i] = m0[i]; s_exp[i] = '0;
        end
        for (int unsigned i = 4; i < 8; i++) begin
            s_we[i] = 1'b0; s_addr[i] = (7 - i) * 4; s_wdata[i] = '0; s_exp[i] = m0[7 - i];
        end
        idx = 0;
        @(negedge clk);
        chk1("w0_ready_start", r0_ready, 1'b1);
        for (int unsigned n = 0; n < 16; n++) begin
            r0_valid = (idx < 8);
            if (idx < 8) begin
                r0_we = s_we[idx]; r0_addr = s_addr[idx]; r0_wdata = s_wdata[idx]; r0_be = 4'hF;
            end
            @(negedge clk);
            if (n % 2 == 0) begin
                chk1("w0_resp_valid", r0_rvalid, 1'b1);
                chk("w0_rdata", r0_rdata, s_exp[idx]);
                chk1("w0_err", r0_err, 1'b0);
                chk1("w0_busy_resp", r0_busy, 1'b1);
                idx++;
            end else begin
                chk1("w0_gap_valid", r0_rvalid, 1'b0);
                chk1("w0_gap_busy", r0_busy, 1'b0);
                chk1("w0_gap_ready", r0_ready, 1'b1);
            end
        end
        r0_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
